// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with freeze, bubble insertion and flush control.
// Every output is a flop. Per-edge priority is flush > hold > bubble > load.
// A bubble keeps the PC and delay-slot flag so a later interrupt can still
// record the right EPC. bubble_cnt counts winning bubbles, saturates instead
// of wrapping, and is cleared only by reset (never by flush).
module pipe_stage_reg #(
  parameter int unsigned DW       = 32,
  parameter int unsigned NDATA    = 3,
  parameter int unsigned AW       = 5,
  parameter int unsigned EXCW     = 5,
  parameter int unsigned CW       = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           in_ir,
  input  logic [31:0]           in_pc,
  input  logic [NDATA*DW-1:0]   in_data,
  input  logic [AW-1:0]         in_a3,
  input  logic                  in_regwrite,
  input  logic                  in_memwrite,
  input  logic                  in_valid,
  input  logic                  in_bd,
  input  logic [EXCW-1:0]       in_exc,
  input  logic                  cond_en,
  input  logic                  cond_ok,
  input  logic                  hold,
  input  logic                  bubble,
  input  logic                  flush,
  output logic [31:0]           out_ir,
  output logic [31:0]           out_pc,
  output logic [NDATA*DW-1:0]   out_data,
  output logic [AW-1:0]         out_a3,
  output logic                  out_regwrite,
  output logic                  out_memwrite,
  output logic                  out_valid,
  output logic                  out_bd,
  output logic [EXCW-1:0]       out_exc,
  output logic [CW-1:0]         bubble_cnt
);

  logic [31:0]         ir_q, ir_d;
  logic [31:0]         pc_q, pc_d;
  logic [NDATA*DW-1:0] data_q, data_d;
  logic [AW-1:0]       a3_q, a3_d;
  logic                regwrite_q, regwrite_d;
  logic                memwrite_q, memwrite_d;
  logic                valid_q, valid_d;
  logic                bd_q, bd_d;
  logic [EXCW-1:0]     exc_q, exc_d;
  logic [CW-1:0]       bcnt_q, bcnt_d;

  logic cond_squash;
  logic exc_squash;

  // Squash conditions for a normal load; they are independent and simply OR.
  always_comb begin
    cond_squash = cond_en & ~cond_ok;
    exc_squash  = (in_exc != '0);
  end

  // Next-state selection in priority order flush > hold > bubble > load.
  always_comb begin
    ir_d       = ir_q;
    pc_d       = pc_q;
    data_d     = data_q;
    a3_d       = a3_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    valid_d    = valid_q;
    bd_d       = bd_q;
    exc_d      = exc_q;
    bcnt_d     = bcnt_q;

    if (flush) begin
      ir_d       = '0;
      pc_d       = RESET_PC;
      data_d     = '0;
      a3_d       = '0;
      regwrite_d = 1'b0;
      memwrite_d = 1'b0;
      valid_d    = 1'b0;
      bd_d       = 1'b0;
      exc_d      = '0;
    end else if (hold) begin
      // everything, bubble_cnt included, keeps its value
    end else if (bubble) begin
      ir_d       = '0;
      pc_d       = in_pc;
      data_d     = '0;
      a3_d       = '0;
      regwrite_d = 1'b0;
      memwrite_d = 1'b0;
      valid_d    = 1'b0;
      bd_d       = in_bd;
      exc_d      = '0;
      if (bcnt_q != {CW{1'b1}}) begin
        bcnt_d = bcnt_q + CW'(1);
      end
    end else begin
      ir_d       = in_ir;
      pc_d       = in_pc;
      data_d     = in_data;
      a3_d       = (cond_squash || exc_squash) ? '0 : in_a3;
      regwrite_d = in_regwrite & ~cond_squash & ~exc_squash;
      memwrite_d = in_memwrite & ~exc_squash;
      valid_d    = in_valid;
      bd_d       = in_bd;
      exc_d      = in_exc;
    end
  end

  // Stage registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q       <= '0;
      pc_q       <= RESET_PC;
      data_q     <= '0;
      a3_q       <= '0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      valid_q    <= 1'b0;
      bd_q       <= 1'b0;
      exc_q      <= '0;
      bcnt_q     <= '0;
    end else begin
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      data_q     <= data_d;
      a3_q       <= a3_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      valid_q    <= valid_d;
      bd_q       <= bd_d;
      exc_q      <= exc_d;
      bcnt_q     <= bcnt_d;
    end
  end

  // Outputs come straight from the flops.
  always_comb begin
    out_ir       = ir_q;
    out_pc       = pc_q;
    out_data     = data_q;
    out_a3       = a3_q;
    out_regwrite = regwrite_q;
    out_memwrite = memwrite_q;
    out_valid    = valid_q;
    out_bd       = bd_q;
    out_exc      = exc_q;
    bubble_cnt   = bcnt_q;
  end

endmodule
